peristaltic_seq: RTL and testbench

Parametrised peristaltic pump sequencer that drives the air-control lines of a chain of `N_VALVES` membrane valves with a timed walking-open pattern. It pumps fluid for a programmable number of strokes in either direction, then parks all valves closed. It sits between the digital controller and the valve array's `air_in` pins, one instance per pump channel.

---
 rtl/peristaltic_seq.sv | 179 +++++++++++++++++
 tb/tb_peristaltic_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/peristaltic_seq.sv
// Peristaltic pump sequencer: walks a single open valve along a chain of
// membrane valves for a programmable number of strokes, then parks all closed.
module peristaltic_seq #(
  parameter int unsigned N_VALVES = 3,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned PH_W     = $clog2(N_VALVES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  strokes,
  output logic [N_VALVES-1:0] valve_air,
  output logic                busy,
  output logic                done,
  output logic [PH_W-1:0]     phase,
  output logic [COUNT_W-1:0]  stroke_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  localparam logic [PH_W-1:0]    PhLast = PH_W'(N_VALVES - 1);
  localparam logic [COUNT_W-1:0] CntMax = '1;

  state_e               state_q, state_d;
  logic                 dir_q, dir_d;
  logic [PERIOD_W-1:0]  per_q, per_d;      // effective phase length, never 0
  logic [COUNT_W-1:0]   strokes_q, strokes_d;
  logic [PERIOD_W-1:0]  timer_q, timer_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 ext_q, ext_d;      // hold entered by stop: one extra cycle
  logic [N_VALVES-1:0]  valve_air_q, valve_air_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 hold_done;
  logic                 wrap;
  logic [PH_W-1:0]      phase_nx;
  logic [COUNT_W-1:0]   cnt_inc;
  logic [PERIOD_W-1:0]  run_last;
  logic [PERIOD_W-1:0]  hold_last;

  assign run_last  = per_q - PERIOD_W'(1);
  // An aborted run holds P+1 cycles, a completed run holds P cycles.
  assign hold_last = run_last + PERIOD_W'(ext_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q       <= 1'b0;
      per_q       <= '0;
      strokes_q   <= '0;
      timer_q     <= '0;
      phase_q     <= '0;
      cnt_q       <= '0;
      ext_q       <= 1'b0;
      valve_air_q <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      dir_q       <= dir_d;
      per_q       <= per_d;
      strokes_q   <= strokes_d;
      timer_q     <= timer_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      ext_q       <= ext_d;
      valve_air_q <= valve_air_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    per_d     = per_q;
    strokes_d = strokes_q;
    timer_d   = timer_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    ext_d     = ext_q;
    hold_done = 1'b0;
    wrap      = 1'b0;
    phase_nx  = phase_q;
    cnt_inc   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d   = StRun;
          dir_d     = dir;
          per_d     = (period == '0) ? PERIOD_W'(1) : period;
          strokes_d = strokes;
          cnt_d     = '0;
          timer_d   = '0;
          ext_d     = 1'b0;
          phase_d   = dir ? PhLast : '0;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StHold;
          timer_d = '0;
          phase_d = '0;
          ext_d   = 1'b1;
        end else if (timer_q == run_last) begin
          timer_d = '0;
          if (dir_q) begin
            wrap     = (phase_q == '0);
            phase_nx = wrap ? PhLast : phase_q - PH_W'(1);
          end else begin
            wrap     = (phase_q == PhLast);
            phase_nx = wrap ? '0 : phase_q + PH_W'(1);
          end
          phase_d = phase_nx;
          if (wrap) begin
            cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + COUNT_W'(1);
            cnt_d   = cnt_inc;
            if ((strokes_q != '0) && (cnt_inc == strokes_q)) begin
              state_d = StHold;
              phase_d = '0;
              ext_d   = 1'b0;
            end
          end
        end else begin
          timer_d = timer_q + PERIOD_W'(1);
        end
      end
      StHold: begin
        if (timer_q == hold_last) begin
          state_d   = StIdle;
          timer_d   = '0;
          ext_d     = 1'b0;
          hold_done = 1'b1;
        end else begin
          timer_d = timer_q + PERIOD_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
        phase_d = '0;
        ext_d   = 1'b0;
      end
    endcase
  end

  // Output decode from the upcoming state, registered on the same edge.
  always_comb begin
    valve_air_d = '1;
    if (state_d == StRun) begin
      valve_air_d = ~(N_VALVES'(1) << phase_d);
    end
    busy_d = (state_d != StIdle);
    done_d = hold_done;
  end

  assign valve_air  = valve_air_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign phase      = phase_q;
  assign stroke_cnt = cnt_q;

endmodule

// File: tb/tb_peristaltic_seq.sv
// Self-checking bench for peristaltic_seq: run-level model checked every cycle
// plus hand-computed literal expectations from the directed scenarios.
module tb_peristaltic_seq;

  localparam int N  = 3;
  localparam int PW = 16;
  localparam int CW = 8;
  localparam int PHW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          dir = 1'b0;
  logic [PW-1:0] period = '0;
  logic [CW-1:0] strokes = '0;
  logic [N-1:0]  valve_air;
  logic          busy;
  logic          done;
  logic [PHW-1:0] phase;
  logic [CW-1:0] stroke_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  peristaltic_seq #(
    .N_VALVES(N),
    .PERIOD_W(PW),
    .COUNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .period    (period),
    .strokes   (strokes),
    .valve_air (valve_air),
    .busy      (busy),
    .done      (done),
    .phase     (phase),
    .stroke_cnt(stroke_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Run-level model: a run is described by its start edge, its length in RUN
  // cycles, and its hold length; outputs follow from the offset into the run.
  bit m_active = 0;
  bit m_stopped = 0;
  int edge_n = 0;
  int m_s, m_P, m_S, m_run_len, m_hold_len;
  bit m_dir;
  int m_cnt_idle = 0;

  function automatic int cnt_end();
    if (m_stopped) return (m_run_len - 1) / (N * m_P);
    return m_S;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active   = 0;
      m_cnt_idle = 0;
    end else begin
      int t;
      edge_n++;
      if (m_active) begin
        t = edge_n - m_s;
        if (!m_stopped && stop && t >= 1 && t <= m_run_len) begin
          m_stopped  = 1;
          m_run_len  = t;
          m_hold_len = m_P + 1;
        end
        if (t > m_run_len + m_hold_len) begin
          m_cnt_idle = cnt_end();
          m_active   = 0;
        end
      end
      if (!m_active && start && !stop) begin
        m_active   = 1;
        m_stopped  = 0;
        m_s        = edge_n;
        m_dir      = dir;
        m_P        = (period == 0) ? 1 : int'(period);
        m_S        = int'(strokes);
        m_run_len  = (strokes == 0) ? 32'h3fff_ffff : int'(strokes) * N * m_P;
        m_hold_len = m_P;
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    logic [N-1:0] e_va;
    logic         e_busy, e_done;
    int           e_ph, e_cnt, t, idx;
    e_va = '1; e_busy = 0; e_done = 0; e_ph = 0; e_cnt = m_cnt_idle;
    if (m_active) begin
      t = edge_n - m_s;
      if (t < m_run_len) begin
        idx    = (t / m_P) % N;
        e_ph   = m_dir ? (N - 1 - idx) : idx;
        e_va   = ~(N'(1) << e_ph);
        e_busy = 1;
        e_cnt  = t / (N * m_P);
      end else begin
        e_cnt = cnt_end();
        if (t < m_run_len + m_hold_len) e_busy = 1;
        else if (t == m_run_len + m_hold_len) e_done = 1;
      end
    end
    chk("model_valve_air", 32'(valve_air), 32'(e_va));
    chk("model_busy", 32'(busy), 32'(e_busy));
    chk("model_done", 32'(done), 32'(e_done));
    chk("model_phase", 32'(phase), 32'(e_ph));
    chk("model_stroke_cnt", 32'(stroke_cnt), 32'(e_cnt));
  end

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Start sampled at the next edge (edge 0); returns in cycle 1 with the
  // latched inputs scrambled to show they are not re-read.
  task automatic start_run(input logic d, input logic [PW-1:0] p, input logic [CW-1:0] s);
    @(negedge clk);
    start = 1; dir = d; period = p; strokes = s;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    start = 0; dir = ~d; period = 16'd7; strokes = 8'd5;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_valve_air", 32'(valve_air), 32'h7);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_cnt", 32'(stroke_cnt), 32'h0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Forward run.
    start_run(1'b0, 16'd4, 8'd2);
    chk("fwd_c1", 32'(valve_air), 32'b110);
    go_to(5);  chk("fwd_c5", 32'(valve_air), 32'b101);
    go_to(9);  chk("fwd_c9", 32'(valve_air), 32'b011);
    go_to(13); chk("fwd_c13", 32'(valve_air), 32'b110);
    go_to(24); chk("fwd_c24", 32'(valve_air), 32'b011);
    go_to(25); chk("fwd_hold_va", 32'(valve_air), 32'b111);
    chk("fwd_hold_busy", 32'(busy), 32'h1);
    go_to(28); chk("fwd_c28_done", 32'(done), 32'h0);
    go_to(29); chk("fwd_done", 32'(done), 32'h1);
    chk("fwd_busy_fall", 32'(busy), 32'h0);
    chk("fwd_cnt", 32'(stroke_cnt), 32'd2);
    go_to(32);

    // Reverse run.
    start_run(1'b1, 16'd4, 8'd2);
    chk("rev_c1", 32'(valve_air), 32'b011);
    go_to(5);  chk("rev_c5", 32'(valve_air), 32'b101);
    go_to(9);  chk("rev_c9", 32'(valve_air), 32'b110);
    go_to(29); chk("rev_done", 32'(done), 32'h1);
    chk("rev_cnt", 32'(stroke_cnt), 32'd2);
    go_to(32);

    // Zero period.
    start_run(1'b0, 16'd0, 8'd1);
    chk("zp_c1", 32'(valve_air), 32'b110);
    go_to(2); chk("zp_c2", 32'(valve_air), 32'b101);
    go_to(3); chk("zp_c3", 32'(valve_air), 32'b011);
    go_to(4); chk("zp_hold", 32'(valve_air), 32'b111);
    go_to(5); chk("zp_done", 32'(done), 32'h1);
    go_to(8);

    // Free-run with stop sampled at edge 9.
    start_run(1'b0, 16'd2, 8'd0);
    go_to(9); stop = 1;
    go_to(10); stop = 0;
    chk("stop_va", 32'(valve_air), 32'b111);
    go_to(12); chk("stop_c12_done", 32'(done), 32'h0);
    go_to(13); chk("stop_done", 32'(done), 32'h1);
    chk("stop_cnt", 32'(stroke_cnt), 32'd1);
    go_to(16);

    // start && stop together in IDLE.
    @(negedge clk); start = 1; stop = 1;
    repeat (3) @(negedge clk);
    chk("ss_busy", 32'(busy), 32'h0);
    start = 0; stop = 0;
    repeat (2) @(negedge clk);

    // start during RUN is ignored.
    start_run(1'b0, 16'd1, 8'd3);
    go_to(4); chk("sr_cnt_c4", 32'(stroke_cnt), 32'd1);
    start = 1;
    go_to(5); start = 0;
    go_to(6); chk("sr_cnt_c6", 32'(stroke_cnt), 32'd1);
    go_to(11); chk("sr_done", 32'(done), 32'h1);
    chk("sr_cnt", 32'(stroke_cnt), 32'd3);
    go_to(14);

    // Reset mid-run during phase 1.
    start_run(1'b0, 16'd4, 8'd2);
    go_to(6);
    chk("rst_pre_va", 32'(valve_air), 32'b101);
    #2 rst_n = 0;
    #1;
    chk("rst_async_va", 32'(valve_air), 32'b111);
    chk("rst_async_busy", 32'(busy), 32'h0);
    chk("rst_async_phase", 32'(phase), 32'h0);
    @(negedge clk); rst_n = 1;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
